instr_mem_loader: RTL and testbench

- Write-side counterpart of the byte-addressed instruction ROM. Accepts 32-bit instruction words over a valid/ready stream and writes each word into the byte-wide instruction memory array, one byte per clock.
- Byte order matches the fetch path: MSB byte goes to address A and LSB byte goes to A+3 (big-endian per word).
- Used at boot or by the testbench to program the instruction memory before releasing the core from reset.

---
 rtl/instr_mem_loader_pkg.sv | 15 +
 rtl/instr_mem_loader_word_byte_serializer.sv | 41 ++++
 rtl/instr_mem_loader.sv | 156 +++++++++++++++
 tb/tb_instr_mem_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Words are 32-bit and are written big-endian, one byte per clock.
package instr_mem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        WRITE     = 2'd2,
        FIN       = 2'd3
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int INSTR_WIDTH    = 32;

endpackage

// File: rtl/instr_mem_loader_word_byte_serializer.sv
// Holds one accepted instruction word and presents it MSB byte first,
// flagging the final byte of the word.
module word_byte_serializer #(
    parameter int WORD_W = 32,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    input  logic [WORD_W-1:0] load_word,
    output logic [BYTE_W-1:0] cur_byte,
    output logic              last_byte
);
    localparam int BYTES = WORD_W / BYTE_W;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [WORD_W-1:0] shift_r;
    logic [IDX_W-1:0]  byte_idx_r;

    // Load a fresh word, or step to the next byte while writing.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_r    <= {WORD_W{1'b0}};
            byte_idx_r <= {IDX_W{1'b0}};
        end else if (load) begin
            shift_r    <= load_word;
            byte_idx_r <= {IDX_W{1'b0}};
        end else if (advance) begin
            shift_r    <= {shift_r[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
            byte_idx_r <= byte_idx_r + IDX_W'(1);
        end else begin
            shift_r    <= shift_r;
            byte_idx_r <= byte_idx_r;
        end
    end

    assign cur_byte  = shift_r[WORD_W-1 -: BYTE_W];
    assign last_byte = (byte_idx_r == IDX_W'(BYTES - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory,
// big-endian per word, after a range check against the memory size.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 8,
    parameter int MEM_DEPTH_LOG2 = 8,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [COUNT_WIDTH-1:0]   word_count,
    input  logic [INSTR_WIDTH-1:0]   in_word,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     we,
    output logic [ADDRESS_WIDTH-1:0] wa,
    output logic [DATA_WIDTH-1:0]    wd,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    localparam int SUM_W = ADDRESS_WIDTH + COUNT_WIDTH + 2;
    localparam logic [SUM_W-1:0] MEM_BYTES = {{(SUM_W-1){1'b0}}, 1'b1} << MEM_DEPTH_LOG2;

    state_t state_r;
    state_t state_s;

    logic [ADDRESS_WIDTH-1:0] addr_r;
    logic [ADDRESS_WIDTH-1:0] wa_hold_r;
    logic [DATA_WIDTH-1:0]    wd_hold_r;
    logic [COUNT_WIDTH-1:0]   words_left_r;
    logic                     err_r;

    logic [SUM_W-1:0]      end_addr_s;
    logic                  out_of_range_s;
    logic                  accept_s;
    logic                  writing_s;
    logic [DATA_WIDTH-1:0] cur_byte_s;
    logic                  last_byte_s;

    // Wide enough that neither operand can overflow, so the check never wraps.
    assign end_addr_s     = SUM_W'(base_addr) + SUM_W'({word_count, 2'b00});
    assign out_of_range_s = (end_addr_s > MEM_BYTES);
    assign accept_s       = (state_r == WAIT_WORD) && in_valid;
    assign writing_s      = (state_r == WRITE);

    word_byte_serializer #(
        .WORD_W (INSTR_WIDTH),
        .BYTE_W (DATA_WIDTH)
    ) u_serializer (
        .clk       (clk),
        .rst       (rst),
        .load      (accept_s),
        .advance   (writing_s),
        .load_word (in_word),
        .cur_byte  (cur_byte_s),
        .last_byte (last_byte_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!start) begin
                    state_s = IDLE;
                end else if (out_of_range_s || (word_count == COUNT_WIDTH'(0))) begin
                    state_s = FIN;
                end else begin
                    state_s = WAIT_WORD;
                end
            end
            WAIT_WORD: begin
                if (in_valid) begin
                    state_s = WRITE;
                end else begin
                    state_s = WAIT_WORD;
                end
            end
            WRITE: begin
                if (!last_byte_s) begin
                    state_s = WRITE;
                end else if (words_left_r == COUNT_WIDTH'(1)) begin
                    state_s = FIN;
                end else begin
                    state_s = WAIT_WORD;
                end
            end
            FIN:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Load bookkeeping: address, remaining words, range error and held write bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r       <= {ADDRESS_WIDTH{1'b0}};
            words_left_r <= {COUNT_WIDTH{1'b0}};
            err_r        <= 1'b0;
            wa_hold_r    <= {ADDRESS_WIDTH{1'b0}};
            wd_hold_r    <= {DATA_WIDTH{1'b0}};
        end else if ((state_r == IDLE) && start) begin
            addr_r       <= base_addr;
            words_left_r <= word_count;
            err_r        <= out_of_range_s;
        end else if (writing_s) begin
            addr_r    <= addr_r + ADDRESS_WIDTH'(1);
            wa_hold_r <= addr_r;
            wd_hold_r <= cur_byte_s;
            if (last_byte_s) begin
                words_left_r <= words_left_r - COUNT_WIDTH'(1);
            end else begin
                words_left_r <= words_left_r;
            end
        end else begin
            addr_r       <= addr_r;
            words_left_r <= words_left_r;
        end
    end

    // Moore output decode; wa/wd keep the last written values while idle.
    always_comb begin
        in_ready = 1'b0;
        we       = 1'b0;
        wa       = wa_hold_r;
        wd       = wd_hold_r;
        busy     = 1'b1;
        done     = 1'b0;
        err      = err_r;
        case (state_r)
            IDLE:      busy     = 1'b0;
            WAIT_WORD: in_ready = 1'b1;
            WRITE: begin
                we = 1'b1;
                wa = addr_r;
                wd = cur_byte_s;
            end
            FIN:       done = 1'b1;
            default:   busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed vector table plus
// randomized loads checked against a byte-level memory model.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic [31:0] in_word;
    logic        in_valid;
    logic        in_ready;
    logic        we;
    logic [31:0] wa;
    logic [7:0]  wd;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;
    logic [7:0] mem_got [0:255];

    typedef struct {
        logic [31:0] base;
        logic [15:0] count;
        int          gap;        // stall cycles before each word, -1 = random
        int          abort_cyc;  // cycle to raise rst, 0 = no abort
        bit          poke;       // pulse start while busy
        bit          exp_err;
        int          exp_writes; // only used for aborted loads
        bit          use_w0;
        logic [31:0] w0;
    } vec_t;

    instr_mem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_word    (in_word),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic bit model_err(input logic [31:0] base, input logic [15:0] count);
        longint unsigned end_addr;
        end_addr = longint'(base) + 4 * longint'(count);
        return end_addr > 256;
    endfunction

    task automatic run_load(input vec_t v);
        logic [31:0] words[$];
        int exp_a[$];
        int exp_d[$];
        int got_a[$];
        int got_d[$];
        int idx = 0;
        int gapcnt = 0;
        int gap_target;
        int stalls = 0;
        int c = 0;
        int done_cnt = 0;
        int done_c = -1;
        bit err_seen = 1'b0;
        bit rdy_bad = 1'b0;
        bit rdy_seen = 1'b0;
        bit wr_ok;
        int exp_done_c;

        for (int i = 0; i < int'(v.count); i++)
            words.push_back((i == 0 && v.use_w0) ? v.w0 : $urandom);
        // Reference: word i byte j lands at base+4i+j, MSB first.
        if (!v.exp_err)
            for (int i = 0; i < int'(v.count); i++)
                for (int j = 0; j < 4; j++) begin
                    exp_a.push_back(int'(v.base) + 4 * i + j);
                    exp_d.push_back(int'((words[i] >> (24 - 8 * j)) & 32'hFF));
                end
        if (v.abort_cyc > 0)
            while (exp_a.size() > v.exp_writes) begin
                void'(exp_a.pop_back());
                void'(exp_d.pop_back());
            end
        gap_target = (v.gap >= 0) ? v.gap : $urandom_range(0, 3);

        start      = 1'b1;
        base_addr  = v.base;
        word_count = v.count;
        in_valid   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            c++;
            if (we) begin
                got_a.push_back(int'(wa));
                got_d.push_back(int'(wd));
                if (wa < 256) mem_got[wa[7:0]] = wd;
            end
            if (we && in_ready) rdy_bad = 1'b1;
            if (in_ready) rdy_seen = 1'b1;
            if (done) begin
                done_cnt++;
                done_c   = c;
                err_seen = err;
            end
            if (v.abort_cyc > 0 && c == v.abort_cyc + 1) begin
                rst = 1'b0;
                check("abort_outputs", {in_ready, we, busy, done}, 4'b0000);
                break;
            end
            if (done || c > 2000) break;
            if (v.abort_cyc > 0 && c == v.abort_cyc) rst = 1'b1;
            if (v.poke && c == 3) begin
                start      = 1'b1;
                base_addr  = 32'h0;
                word_count = 16'd5;
            end else begin
                start = 1'b0;
            end
            if (idx < int'(v.count)) begin
                if (in_ready && gapcnt < gap_target) begin
                    in_valid = 1'b0;
                    gapcnt++;
                    stalls++;
                end else begin
                    in_valid = 1'b1;
                    in_word  = words[idx];
                    if (in_ready) begin
                        idx++;
                        gapcnt     = 0;
                        gap_target = (v.gap >= 0) ? v.gap : $urandom_range(0, 3);
                    end
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (c > 2000) check("timeout", 64'(c), 64'd0);

        wr_ok = (got_a.size() == exp_a.size());
        if (wr_ok)
            foreach (exp_a[k])
                if (got_a[k] != exp_a[k] || got_d[k] != exp_d[k]) wr_ok = 1'b0;
        check("write_count", 64'(got_a.size()), 64'(exp_a.size()));
        check("write_seq", 64'(wr_ok), 64'd1);
        check("ready_in_write", 64'(rdy_bad), 64'd0);
        if (exp_a.size() == 0 && v.abort_cyc == 0)
            check("ready_never", 64'(rdy_seen), 64'd0);

        if (v.abort_cyc > 0) begin
            check("abort_no_done", 64'(done_cnt), 64'd0);
            @(posedge clk);
            #1;
            check("abort_idle", {busy, done, we, in_ready}, 4'b0000);
        end else begin
            exp_done_c = (v.exp_err || v.count == 16'd0) ? 1 : 1 + 5 * int'(v.count) + stalls;
            check("done_count", 64'(done_cnt), 64'd1);
            check("err", 64'(err_seen), 64'(v.exp_err));
            check("done_cycle", 64'(done_c), 64'(exp_done_c));
            if (v.use_w0)
                check("fetch_readback",
                      {mem_got[v.base[7:0]], mem_got[v.base[7:0] + 8'd1],
                       mem_got[v.base[7:0] + 8'd2], mem_got[v.base[7:0] + 8'd3]}, 64'(v.w0));
            @(posedge clk);
            #1;
            check("idle_after", {busy, done, in_ready, we}, 4'b0000);
        end
    endtask

    vec_t vecs[$];
    vec_t rv;

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        base_addr  = 32'h0;
        word_count = 16'h0;
        in_word    = 32'h0;
        in_valid   = 1'b0;
        foreach (mem_got[k]) mem_got[k] = 8'h00;

        //         base      count  gap abort poke err wr use_w0 w0
        vecs.push_back('{32'h00,  16'd1, 0, 0, 1'b0, 1'b0, 0, 1'b1, 32'h00500093});
        vecs.push_back('{32'h10,  16'd3, 2, 0, 1'b0, 1'b0, 0, 1'b0, 32'h0});
        vecs.push_back('{32'h20,  16'd0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 32'h0});
        vecs.push_back('{32'hF8,  16'd3, 0, 0, 1'b0, 1'b1, 0, 1'b0, 32'h0});
        vecs.push_back('{32'hFC,  16'd1, 0, 0, 1'b0, 1'b0, 0, 1'b1, 32'hDEADBEEF});
        vecs.push_back('{32'h40,  16'd3, 0, 9, 1'b0, 1'b0, 7, 1'b0, 32'h0});
        vecs.push_back('{32'h80,  16'd2, 0, 0, 1'b1, 1'b0, 0, 1'b0, 32'h0});
        vecs.push_back('{32'h100, 16'd0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 32'h0});
        vecs.push_back('{32'h101, 16'd0, 0, 0, 1'b0, 1'b1, 0, 1'b0, 32'h0});
        vecs.push_back('{32'hF0,  16'd4, 1, 0, 1'b0, 1'b0, 0, 1'b0, 32'h0});
        vecs.push_back('{32'hF0,  16'd5, 0, 0, 1'b0, 1'b1, 0, 1'b0, 32'h0});

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {in_ready, we, busy, done, err}, 5'b00000);
        check("reset_wa_wd", {wa, wd}, 40'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) run_load(vecs[i]);

        for (int n = 0; n < 25; n++) begin
            rv.base      = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(200, 300))
                                                       : 32'($urandom_range(0, 255));
            rv.count     = 16'($urandom_range(0, 8));
            rv.gap       = -1;
            rv.abort_cyc = 0;
            rv.poke      = ($urandom_range(0, 3) == 0);
            rv.exp_err   = model_err(rv.base, rv.count);
            rv.exp_writes = 0;
            rv.use_w0    = 1'b0;
            rv.w0        = 32'h0;
            run_load(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
